// File: rtl/cmul_sequencer.sv
// cmul_sequencer: one complex product a*w per transaction, using one shared
// NxN real multiplier over four cycles, then round-half-up and saturate.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          operand handshake (ready only in IDLE)
//   a_re, a_im, w_re, w_im     signed Q1.(N-1) sample and twiddle
//   out_valid/out_ready        result handshake (held until accepted)
//   out_re, out_im             rounded, saturated signed product
//   busy                       high whenever not IDLE
//   mul_y, mul_x, mul_result   shared multiplier operands and 2N-bit product
module cmul_sequencer #(
    parameter int N = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   a_re,
    input  logic signed [N-1:0]   a_im,
    input  logic signed [N-1:0]   w_re,
    input  logic signed [N-1:0]   w_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [N-1:0]   out_re,
    output logic signed [N-1:0]   out_im,
    output logic                  busy,
    output logic signed [N-1:0]   mul_y,
    output logic signed [N-1:0]   mul_x,
    input  logic signed [2*N-1:0] mul_result
);

    localparam int ACC_W = 2 * N + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MRR  = 3'd1;
    localparam logic [2:0] S_MII  = 3'd2;
    localparam logic [2:0] S_MRI  = 3'd3;
    localparam logic [2:0] S_MIR  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Rounding offset is half an output LSB; clamp limits in accumulator width.
    localparam logic signed [ACC_W-1:0] HALF =
        {{(N + 2){1'b0}}, 1'b1, {(N - 2){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V =
        {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

    logic [2:0]              state_q, state_d;
    logic signed [N-1:0]     a_re_q, a_re_d;
    logic signed [N-1:0]     a_im_q, a_im_d;
    logic signed [N-1:0]     w_re_q, w_re_d;
    logic signed [N-1:0]     w_im_q, w_im_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
    logic signed [ACC_W-1:0] p_ext;

    function automatic logic signed [N-1:0] sat_round(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] r;
        logic signed [N-1:0]     res;
        r = (acc + HALF) >>> (N - 1);
        if (r > MAX_V) begin
            res = MAX_V[N-1:0];
        end else if (r < MIN_V) begin
            res = MIN_V[N-1:0];
        end else begin
            res = r[N-1:0];
        end
        return res;
    endfunction

    assign p_ext     = {mul_result[2*N-1], mul_result};
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_re    = out_valid ? sat_round(acc_re_q) : '0;
    assign out_im    = out_valid ? sat_round(acc_im_q) : '0;

    // Operand mux kept apart from the accumulator logic so the external
    // multiplier path mul_y/mul_x -> mul_result never looks like a loop.
    always_comb begin
        mul_y = '0;
        mul_x = '0;
        case (state_q)
            S_MRR: begin
                mul_y = a_re_q;
                mul_x = w_re_q;
            end
            S_MII: begin
                mul_y = a_im_q;
                mul_x = w_im_q;
            end
            S_MRI: begin
                mul_y = a_re_q;
                mul_x = w_im_q;
            end
            S_MIR: begin
                mul_y = a_im_q;
                mul_x = w_re_q;
            end
            default: begin
                mul_y = '0;
                mul_x = '0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_re_d   = a_re_q;
        a_im_d   = a_im_q;
        w_re_d   = w_re_q;
        w_im_d   = w_im_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_re_d  = a_re;
                    a_im_d  = a_im;
                    w_re_d  = w_re;
                    w_im_d  = w_im;
                    state_d = S_MRR;
                end
            end
            S_MRR: begin
                acc_re_d = p_ext;
                state_d  = S_MII;
            end
            S_MII: begin
                acc_re_d = acc_re_q - p_ext;
                state_d  = S_MRI;
            end
            S_MRI: begin
                acc_im_d = p_ext;
                state_d  = S_MIR;
            end
            S_MIR: begin
                acc_im_d = acc_im_q + p_ext;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_re_q   <= '0;
            a_im_q   <= '0;
            w_re_q   <= '0;
            w_im_q   <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            state_q  <= state_d;
            a_re_q   <= a_re_d;
            a_im_q   <= a_im_d;
            w_re_q   <= w_re_d;
            w_im_q   <= w_im_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

endmodule

// File: tb/tb_cmul_sequencer.sv
// tb_cmul_sequencer: directed bench for cmul_sequencer with a behavioural
// shared multiplier and a longint golden model for round/saturate.
module tb_cmul_sequencer;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a_re, a_im, w_re, w_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re, out_im;
    logic               busy;
    logic signed [15:0] mul_y, mul_x;
    logic signed [31:0] mul_result;

    int checks = 0;
    int errors = 0;

    assign mul_result = mul_y * mul_x;

    cmul_sequencer #(.N(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .busy(busy),
        .mul_y(mul_y), .mul_x(mul_x), .mul_result(mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [15:0] gold(input longint p);
        longint r;
        r = (p + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic logic [15:0] gold_re(input logic [15:0] ar, ai, wr, wi);
        return gold(sx(ar) * sx(wr) - sx(ai) * sx(wi));
    endfunction

    function automatic logic [15:0] gold_im(input logic [15:0] ar, ai, wr, wi);
        return gold(sx(ar) * sx(wi) + sx(ai) * sx(wr));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one operand pair across one accept edge.
    task automatic send(input logic [15:0] ar, ai, wr, wi);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
        a_re = ar; a_im = ai; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %0b required 0", in_ready);
        end
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got v=%0b b=%0b required 0 0",
                     out_valid, busy);
        end
        checks++;
        if ({out_re, out_im, mul_y, mul_x} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h required 0",
                     out_re, out_im, mul_y, mul_x);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got %0b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ey [4];
        logic [15:0] ex [4];
        ey = '{16'h4000, 16'h0000, 16'h4000, 16'h0000};
        ex = '{16'h4000, 16'h0000, 16'h0000, 16'h4000};
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mul_y !== ey[k] || mul_x !== ex[k]) begin
                errors++;
                $display("FAIL basic_mul_ops%0d got %h,%h required %h,%h",
                         k, mul_y, mul_x, ey[k], ex[k]);
            end
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy%0d got b=%0b v=%0b r=%0b required 1 0 0",
                         k, busy, out_valid, in_ready);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done got v=%0b b=%0b required 1 1",
                     out_valid, busy);
        end
        checks++;
        if (out_re !== 16'h2000 || out_im !== 16'h0000) begin
            errors++;
            $display("FAIL basic_result got %h,%h required 2000,0000",
                     out_re, out_im);
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got v=%0b r=%0b b=%0b required 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_rotation();
        int c;
        send(16'h4000, 16'h2000, 16'h0000, 16'h7FFF);
        wait_valid(c);
        checks++;
        if (c != 4) begin
            errors++;
            $display("FAIL rot_latency got %0d required 4", c);
        end
        checks++;
        if (out_re !== 16'hE000 || out_im !== 16'h4000) begin
            errors++;
            $display("FAIL rot_result got %h,%h required e000,4000",
                     out_re, out_im);
        end
        release_result();
    endtask

    task automatic test_saturation();
        int c;
        send(16'h8000, 16'h0000, 16'h8000, 16'h0000);
        wait_valid(c);
        checks++;
        if (out_valid !== 1'b1 || out_re !== 16'h7FFF || out_im !== 16'h0000) begin
            errors++;
            $display("FAIL sat_re got v=%0b %h,%h required 1 7fff,0000",
                     out_valid, out_re, out_im);
        end
        release_result();
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        wait_valid(c);
        checks++;
        if (out_valid !== 1'b1 || out_re !== 16'h0000 || out_im !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_im got v=%0b %h,%h required 1 0000,7fff",
                     out_valid, out_re, out_im);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int c;
        logic [15:0] er, ei, nr, ni;
        er = gold_re(16'h1234, 16'h5678, 16'h7000, 16'h9000);
        ei = gold_im(16'h1234, 16'h5678, 16'h7000, 16'h9000);
        nr = gold_re(16'hC000, 16'h3000, 16'h5A82, 16'hA57E);
        ni = gold_im(16'hC000, 16'h3000, 16'h5A82, 16'hA57E);
        send(16'h1234, 16'h5678, 16'h7000, 16'h9000);
        wait_valid(c);
        a_re = 16'hC000; a_im = 16'h3000; w_re = 16'h5A82; w_im = 16'hA57E;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_re !== er || out_im !== ei) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%0b r=%0b %h,%h required 1 0 %h,%h",
                         k, out_valid, in_ready, out_re, out_im, er, ei);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%0b r=%0b required 0 1",
                     out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || mul_y !== 16'hC000 || mul_x !== 16'h5A82) begin
            errors++;
            $display("FAIL bp_accept got b=%0b %h,%h required 1 c000,5a82",
                     busy, mul_y, mul_x);
        end
        wait_valid(c);
        checks++;
        if (out_valid !== 1'b1 || out_re !== nr || out_im !== ni) begin
            errors++;
            $display("FAIL bp_next got v=%0b %h,%h required 1 %h,%h",
                     out_valid, out_re, out_im, nr, ni);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        send(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        step();
        step();
        checks++;
        if (mul_y !== 16'h4000 || mul_x !== 16'h4000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_mri got %h,%h b=%0b required 4000,4000 1",
                     mul_y, mul_x, busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got b=%0b v=%0b r=%0b required 0 0 0",
                     busy, out_valid, in_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got r=%0b b=%0b required 1 0",
                     in_ready, busy);
        end
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (out_valid) seen++;
                step();
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL mid_spurious got %0d valid cycles required 0", seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s_ar [8];
        logic [15:0] s_ai [8];
        logic [15:0] s_wr [8];
        logic [15:0] s_wi [8];
        logic [15:0] ey [4];
        logic [15:0] ex [4];
        logic [31:0] r;
        int idx, cur, last_acc, nres, phase;
        bit acc;
        for (int i = 0; i < 8; i++) begin
            r = $urandom(); s_ar[i] = r[15:0]; s_ai[i] = r[31:16];
            r = $urandom(); s_wr[i] = r[15:0]; s_wi[i] = r[31:16];
        end
        idx = 0; cur = 0; last_acc = -1; nres = 0; phase = -1;
        a_re = s_ar[0]; a_im = s_ai[0]; w_re = s_wr[0]; w_im = s_wi[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && nres < 8; cyc++) begin
            acc = in_ready && in_valid;
            if (phase >= 1 && phase <= 4) begin
                ey = '{s_ar[cur], s_ai[cur], s_ar[cur], s_ai[cur]};
                ex = '{s_wr[cur], s_wi[cur], s_wi[cur], s_wr[cur]};
                checks++;
                if (mul_y !== ey[phase-1] || mul_x !== ex[phase-1]) begin
                    errors++;
                    $display("FAIL stream_ops t%0d p%0d got %h,%h required %h,%h",
                             cur, phase, mul_y, mul_x, ey[phase-1], ex[phase-1]);
                end
            end
            if (phase == 5) begin
                checks++;
                if (out_valid !== 1'b1 ||
                    out_re !== gold_re(s_ar[cur], s_ai[cur], s_wr[cur], s_wi[cur]) ||
                    out_im !== gold_im(s_ar[cur], s_ai[cur], s_wr[cur], s_wi[cur])) begin
                    errors++;
                    $display("FAIL stream_result t%0d got v=%0b %h,%h required 1 %h,%h",
                             cur, out_valid, out_re, out_im,
                             gold_re(s_ar[cur], s_ai[cur], s_wr[cur], s_wi[cur]),
                             gold_im(s_ar[cur], s_ai[cur], s_wr[cur], s_wi[cur]));
                end
                nres++;
            end
            if (acc) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 6) begin
                        errors++;
                        $display("FAIL stream_spacing got %0d required 6",
                                 cyc - last_acc);
                    end
                end
                last_acc = cyc;
                cur = idx;
                idx++;
            end
            step();
            if (acc) begin
                phase = 1;
                if (idx < 8) begin
                    a_re = s_ar[idx]; a_im = s_ai[idx];
                    w_re = s_wr[idx]; w_im = s_wi[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end else if (phase >= 0) begin
                phase++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nres != 8) begin
            errors++;
            $display("FAIL stream_count got %0d required 8", nres);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_re = '0; a_im = '0; w_re = '0; w_im = '0;
        test_reset();
        test_basic();
        test_rotation();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
